// File: rtl/mixer_pkg.sv
// Shared constants, state encoding and sample helpers for the audio mixer.
package mixer_pkg;

  localparam int NUM_CH   = 8;
  localparam int SAMPLE_W = 8;
  localparam int MIX_W    = 11;
  localparam int IDX_W    = $clog2(NUM_CH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Zero a muted channel, otherwise pass the sample through unchanged.
  function automatic logic [SAMPLE_W-1:0] gate_sample(input logic [SAMPLE_W-1:0] s,
                                                      input logic              muted);
    return muted ? '0 : s;
  endfunction

  // Zero-extend a channel sample to the accumulator width.
  function automatic logic [MIX_W-1:0] widen(input logic [SAMPLE_W-1:0] s);
    return {{(MIX_W-SAMPLE_W){1'b0}}, s};
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running sample-period counter; tick pulses for one cycle at the last count.
module tick_divider #(
  parameter int TICK_DIV = 1134
) (
  input  logic CLOCK_50,
  input  logic resetn,
  output logic tick
);

  localparam int              CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;

  // Count 0..TICK_DIV-1 and wrap.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/mix_scheduler.sv
// Captures eight channel samples on each sample tick, sums them one per cycle,
// and holds the sum with a valid/ready handshake toward the consumer.
module mix_scheduler
  import mixer_pkg::*;
#(
  parameter int TICK_DIV = 1134
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic [SAMPLE_W-1:0] audio0,
  input  logic [SAMPLE_W-1:0] audio1,
  input  logic [SAMPLE_W-1:0] audio2,
  input  logic [SAMPLE_W-1:0] audio3,
  input  logic [SAMPLE_W-1:0] audio4,
  input  logic [SAMPLE_W-1:0] audio5,
  input  logic [SAMPLE_W-1:0] audio6,
  input  logic [SAMPLE_W-1:0] audio7,
  input  logic [NUM_CH-1:0]   mute_mask,
  input  logic                mix_ready,
  output logic [MIX_W-1:0]    mix_out,
  output logic                mix_valid,
  output logic                busy,
  output logic                overrun
);

  logic                tick;
  state_t              state;
  state_t              state_next;
  logic [SAMPLE_W-1:0] audio_in [NUM_CH];
  logic [SAMPLE_W-1:0] sample   [NUM_CH];
  logic [MIX_W-1:0]    acc;
  logic [MIX_W-1:0]    acc_sum;
  logic [IDX_W-1:0]    idx;
  logic                capture;
  logic                add;
  logic                finish;
  logic                drop;
  logic                xfer;

  tick_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .tick     (tick)
  );

  assign audio_in[0] = audio0;
  assign audio_in[1] = audio1;
  assign audio_in[2] = audio2;
  assign audio_in[3] = audio3;
  assign audio_in[4] = audio4;
  assign audio_in[5] = audio5;
  assign audio_in[6] = audio6;
  assign audio_in[7] = audio7;

  // Unsigned running sum; 8 x 255 = 2040 always fits in MIX_W bits.
  assign acc_sum = acc + widen(sample[idx]);
  assign xfer    = (state == HOLD) && mix_valid && mix_ready;
  assign busy    = (state != IDLE);

  // State register.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath strobes; a tick that cannot start a capture is dropped.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    add        = 1'b0;
    finish     = 1'b0;
    drop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (tick) begin
          capture    = 1'b1;
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        add  = 1'b1;
        drop = tick;
        if (idx == IDX_W'(NUM_CH - 1)) begin
          finish     = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (xfer) begin
          if (tick) begin
            capture    = 1'b1;
            state_next = ACCUM;
          end else begin
            state_next = IDLE;
          end
        end else begin
          drop = tick;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Snapshot the channels (with muting) so later input changes cannot disturb the sum.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_CH; i++) sample[i] <= '0;
    end else if (capture) begin
      for (int i = 0; i < NUM_CH; i++) sample[i] <= gate_sample(audio_in[i], mute_mask[i]);
    end
  end

  // Accumulate one captured channel per cycle, lowest index first.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      acc <= '0;
      idx <= '0;
    end else if (capture) begin
      acc <= '0;
      idx <= '0;
    end else if (add) begin
      acc <= acc_sum;
      idx <= idx + IDX_W'(1);
    end
  end

  // Present the finished sum and hold it until the consumer takes it.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      mix_out   <= '0;
      mix_valid <= 1'b0;
    end else if (finish) begin
      mix_out   <= acc_sum;
      mix_valid <= 1'b1;
    end else if (xfer) begin
      mix_valid <= 1'b0;
    end
  end

  // Sticky record of any sample tick that was not captured.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mix_scheduler.sv
// Self-checking bench for mix_scheduler: directed scenarios plus random traffic
// compared against a timing-level reference model of the sample scheduler.
module tb_mix_scheduler;

  localparam int TD = 12;

  logic        CLOCK_50 = 1'b0;
  logic        resetn;
  logic [7:0]  audio [8];
  logic [7:0]  mute_mask;
  logic        mix_ready;
  logic [10:0] mix_out;
  logic        mix_valid;
  logic        busy;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  // stimulus controls
  int         ready_mode;   // 0 random, 1 high, 2 low, 3 high only on tick cycles
  int         audio_mode;   // 0 random, 1 fixed table
  logic [7:0] fix_audio [8];
  logic [7:0] fix_mute;

  // reference model: cycle number since reset release, job timing and output view
  int cyc;
  bit m_job;
  int m_done_at;
  int m_job_sum;
  bit m_valid;
  int m_out;
  bit m_ovr;

  mix_scheduler #(
    .TICK_DIV (TD)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .resetn    (resetn),
    .audio0    (audio[0]),
    .audio1    (audio[1]),
    .audio2    (audio[2]),
    .audio3    (audio[3]),
    .audio4    (audio[4]),
    .audio5    (audio[5]),
    .audio6    (audio[6]),
    .audio7    (audio[7]),
    .mute_mask (mute_mask),
    .mix_ready (mix_ready),
    .mix_out   (mix_out),
    .mix_valid (mix_valid),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t cyc=%0d)", tag, got, exp, $time, cyc);
    end
  endtask

  task automatic set_fixed(input int base, input int stride, input logic [7:0] m);
    for (int i = 0; i < 8; i++) fix_audio[i] = 8'(base + stride * i);
    fix_mute   = m;
    audio_mode = 1;
  endtask

  // The model's view of a capture: sum of unmuted inputs, ready 9 cycles later.
  task automatic model_start();
    int s;
    s = 0;
    for (int i = 0; i < 8; i++) if (!mute_mask[i]) s += audio[i];
    m_job     = 1'b1;
    m_job_sum = s;
    m_done_at = cyc + 9;
  endtask

  // One cycle: compare outputs, drive next inputs, advance the model, move to next negedge.
  task automatic cycle_step();
    bit tick;
    bit xfer;
    check_eq("mix_valid", mix_valid, m_valid);
    check_eq("mix_out", mix_out, m_out);
    check_eq("busy", busy, m_job || m_valid);
    check_eq("overrun", overrun, m_ovr);

    case (ready_mode)
      0:       mix_ready = 1'($urandom_range(0, 1));
      1:       mix_ready = 1'b1;
      2:       mix_ready = 1'b0;
      default: mix_ready = ((cyc % TD) == TD - 1);
    endcase
    if (audio_mode == 0) begin
      for (int i = 0; i < 8; i++) audio[i] = 8'($urandom_range(0, 255));
      mute_mask = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
    end else begin
      for (int i = 0; i < 8; i++) audio[i] = fix_audio[i];
      mute_mask = fix_mute;
    end

    tick = ((cyc % TD) == TD - 1);
    xfer = m_valid && mix_ready;
    if (m_valid) begin
      if (xfer) begin
        m_valid = 1'b0;
        if (tick) model_start();
      end else if (tick) begin
        m_ovr = 1'b1;
      end
    end else if (m_job) begin
      if (tick) m_ovr = 1'b1;
      if (cyc + 1 == m_done_at) begin
        m_job   = 1'b0;
        m_valid = 1'b1;
        m_out   = m_job_sum;
      end
    end else if (tick) begin
      model_start();
    end

    @(negedge CLOCK_50);
    cyc++;
  endtask

  // Called at a negedge: assert reset, check outputs at once, release at a later negedge.
  task automatic apply_reset();
    resetn = 1'b0;
    #1;
    check_eq("rst_mix_out", mix_out, 0);
    check_eq("rst_mix_valid", mix_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_overrun", overrun, 0);
    @(negedge CLOCK_50);
    check_eq("rst_hold_valid", mix_valid, 0);
    check_eq("rst_hold_busy", busy, 0);
    @(negedge CLOCK_50);
    resetn    = 1'b1;
    cyc       = 0;
    m_job     = 1'b0;
    m_valid   = 1'b0;
    m_out     = 0;
    m_ovr     = 1'b0;
    m_done_at = 0;
  endtask

  task automatic run_until_valid(input int budget);
    int n;
    n = 0;
    while (!mix_valid && n < budget) begin
      cycle_step();
      n++;
    end
    check_eq("valid_seen", mix_valid, 1);
  endtask

  initial begin
    int   held;
    bit   prev_v;
    int   n;
    resetn     = 1'b0;
    mix_ready  = 1'b0;
    mute_mask  = 8'h00;
    for (int i = 0; i < 8; i++) audio[i] = 8'h00;
    ready_mode = 1;
    set_fixed(1, 1, 8'h00);
    @(negedge CLOCK_50);

    // channels 1..8 with ready high: 36 every period, valid 9 cycles after each tick
    apply_reset();
    ready_mode = 1;
    set_fixed(1, 1, 8'h00);
    prev_v = 1'b0;
    repeat (72) begin
      cycle_step();
      if (mix_valid) check_eq("sum_1_to_8", mix_out, 36);
      if (mix_valid && !prev_v) check_eq("valid_rise_phase", cyc % TD, (TD - 1 + 9) % TD);
      prev_v = mix_valid;
    end
    check_eq("no_overrun_ready_high", overrun, 0);

    // full scale, then upper four channels muted
    apply_reset();
    set_fixed(255, 0, 8'h00);
    run_until_valid(40);
    check_eq("sum_full_scale", mix_out, 2040);
    apply_reset();
    set_fixed(255, 0, 8'hF0);
    run_until_valid(40);
    check_eq("sum_mute_f0", mix_out, 1020);

    // inputs zeroed right after capture must not change the sum in progress
    apply_reset();
    set_fixed(10, 10, 8'h00);
    n = 0;
    while (!busy && n < 40) begin
      cycle_step();
      n++;
    end
    check_eq("capture_seen", busy, 1);
    for (int i = 0; i < 8; i++) fix_audio[i] = 8'h00;
    fix_mute = 8'hFF;
    run_until_valid(20);
    check_eq("sum_after_input_change", mix_out, 360);

    // consumer stalls for 30 cycles with one sum pending
    apply_reset();
    set_fixed(1, 1, 8'h00);
    ready_mode = 2;
    run_until_valid(40);
    held = mix_out;
    repeat (30) begin
      cycle_step();
      check_eq("hold_stable", mix_out, held);
      check_eq("hold_valid", mix_valid, 1);
    end
    check_eq("overrun_after_stall", overrun, 1);
    ready_mode = 1;
    cycle_step();
    check_eq("stall_xfer_valid", mix_valid, 0);
    check_eq("stall_back_idle", busy, 0);

    // ready rises exactly on the tick cycle while holding
    apply_reset();
    set_fixed(3, 2, 8'h00);
    ready_mode = 3;
    while (cyc < 24) cycle_step();
    check_eq("tick_xfer_busy", busy, 1);
    check_eq("tick_xfer_valid", mix_valid, 0);
    check_eq("tick_xfer_overrun", overrun, 0);
    while (cyc < 60) cycle_step();
    check_eq("tick_xfer_overrun_late", overrun, 0);

    // reset while the index-4 channel is being added
    apply_reset();
    set_fixed(1, 1, 8'h00);
    ready_mode = 1;
    n = 0;
    while (!(m_job && (m_done_at - cyc) == 4) && n < 40) begin
      cycle_step();
      n++;
    end
    check_eq("reached_index4", busy, 1);
    apply_reset();
    n = 0;
    while (!busy && cyc < 3 * TD) begin
      check_eq("no_valid_after_abort", mix_valid, 0);
      cycle_step();
    end
    check_eq("first_capture_cycle", cyc, TD);

    // random traffic against the model
    apply_reset();
    ready_mode = 0;
    audio_mode = 0;
    repeat (600) cycle_step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
